can_error_frame_tx: RTL and testbench
=====================================

Name: can_error_frame_tx

Overview:
Transmit-side counterpart of the CAN decoder's error detection. It consumes the active-low error indication and drives a CAN error frame on the TX line, bit-aligned to the transmit bit tick. The frame is an error flag of 6 bits (dominant when error-active, recessive when error-passive) followed by an 8-bit recessive delimiter. It also maintains the transmit error counter (TEC) and the error-passive and bus-off state. It sits between the error block and the TX bit mux of the controller.

Parameters:
FLAG_LEN, 6, error flag length in bits
DELIM_LEN, 8, error delimiter length in bits (recessive)
MAX_DOM_WAIT, 14, consecutive dominant bits tolerated while waiting for the delimiter before a further TEC penalty
BUSOFF_RECOVER, 1408, consecutive recessive bits (128 x 11) needed to leave bus-off

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
bit_tick  in  1  one-clk pulse at each TX bit boundary
rx_bit  in  1  bus level sampled at the last sample point (1 = recessive)
err_n  in  1  error indication, active-low, level; 0 requests an error frame
tx_ok  in  1  one-clk pulse on a successfully transmitted frame
tx_bit  out  1  bus drive (1 = recessive)
busy  out  1  high while an error frame is in progress
err_passive  out  1  high when TEC >= 128
bus_off  out  1  high in BUS_OFF state
tec  out  9  transmit error counter

Behaviour:
- Reset (async): state = IDLE, tx_bit = 1, busy = 0, tec = 0, err_passive = 0, bus_off = 0, all bit counters = 0, pending request = 0.
- Request latch: in IDLE, err_n == 0 on any clk sets pending. The latch is cleared on entry to FLAG. Requests seen outside IDLE are ignored.
- All state transitions and bit counting happen only on clk edges where bit_tick = 1. tx_bit changes only on those edges (1-bit-time latency from the request to the first flag bit at worst).
- IDLE: tx_bit = 1.
  - On bit_tick with pending = 1: go to FLAG, cnt = 0, tec += 8.
  - Otherwise, tx_ok = 1 with tec > 0 gives tec -= 1. If a request and tx_ok coincide, the request wins and there is no decrement.
- FLAG: tx_bit = err_passive ? 1 : 0; busy = 1.
  - Each bit_tick: cnt++.
  - At cnt == FLAG_LEN-1 with bit_tick: go to DELIM_WAIT, dcnt = 0.
- DELIM_WAIT: tx_bit = 1; busy = 1. Each bit_tick:
  - rx_bit == 1: go to DELIM, cnt = 1 (the first recessive bit counts).
  - Otherwise dcnt++. When dcnt reaches MAX_DOM_WAIT: tec += 8, dcnt = 0, stay in DELIM_WAIT.
- DELIM: tx_bit = 1; busy = 1. Each bit_tick:
  - rx_bit == 0: form error. Go to FLAG, cnt = 0, tec += 8.
  - Else cnt++. At cnt == DELIM_LEN-1: go to IDLE.
- TEC arithmetic:
  - 9-bit, saturating at 511. tec never decrements below 0.
  - err_passive = (tec >= 128), combinational from tec.
  - Any update bringing tec >= 256 forces BUS_OFF on the same edge, overriding the normal next state.
- BUS_OFF: tx_bit = 1; bus_off = 1; busy = 0. rcnt counts consecutive bit_ticks with rx_bit == 1 and clears on rx_bit == 0. At rcnt == BUSOFF_RECOVER-1: tec = 0, go to IDLE. err_n and tx_ok are ignored in BUS_OFF.
- Reset mid-frame: tx_bit returns to recessive immediately (async) and the frame is abandoned.

Optional Feature:
ERR_FRAME_STATS_EN
- Defined: adds output err_frames[15:0], saturating at 0xFFFF. It increments on every entry to FLAG, including form-error restarts, and resets to 0 on reset.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package can_err_pkg holds:
  - the state enum (IDLE, FLAG, DELIM_WAIT, DELIM, BUS_OFF)
  - TEC constants: TEC_ERR_INC = 8, TEC_PASSIVE = 128, TEC_BUSOFF = 256, TEC_W = 9
  - the default FLAG_LEN / DELIM_LEN values
- One sub-module, can_tec_counter: a saturating 9-bit inc-by-8 / dec-by-1 counter with a clear input, whose outputs drive err_passive and the bus-off request. The FSM and bit counters stay in the top module.

Test Plan:
- Active error: reset, tec = 0; err_n low for 1 clk → next bit_tick gives tx_bit = 0 for exactly 6 bit ticks, then 8 recessive (rx_bit = 1); tec = 8; busy falls on the 14th tick.
- Decrement: from tec = 8, 3 tx_ok pulses in IDLE → tec = 5; err_n low coinciding with tx_ok → tec = 13, with no decrement.
- Passive flag: preload to tec = 128 via 16 error frames → err_passive = 1; the next error flag is 6 recessive bits; tec = 136.
- Delimiter wait: hold rx_bit = 0 for 20 bits after the flag → one extra +8 at the 14th dominant bit; release → the delimiter completes after 8 recessive bits.
- Form error: rx_bit = 0 at delimiter bit 4 → FLAG restarts immediately, tec += 8, and with ERR_FRAME_STATS_EN err_frames increments by 2 in total.
- Bus-off: drive tec to 256 → bus_off = 1, tx_bit = 1; 1407 recessive ticks → still bus-off; the 1408th → IDLE, tec = 0. A dominant bit mid-count restarts rcnt. Async reset mid-FLAG → tx_bit = 1 immediately.

Source files
------------

// File: rtl/can_err_pkg.sv
// Shared definitions for the CAN error-frame transmitter: FSM state codes,
// transmit-error-counter constants and default frame field lengths.
// No ports; imported by can_tec_counter and can_error_frame_tx.
package can_err_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FLAG       = 3'd1;
    localparam logic [2:0] ST_DELIM_WAIT = 3'd2;
    localparam logic [2:0] ST_DELIM      = 3'd3;
    localparam logic [2:0] ST_BUS_OFF    = 3'd4;

    // Transmit error counter
    localparam int              TEC_W       = 9;
    localparam logic [TEC_W-1:0] TEC_ERR_INC = 9'd8;
    localparam logic [TEC_W-1:0] TEC_PASSIVE = 9'd128;
    localparam logic [TEC_W-1:0] TEC_BUSOFF  = 9'd256;

    // Default error frame field lengths, in bits
    localparam int FLAG_LEN_DEF  = 6;
    localparam int DELIM_LEN_DEF = 8;

endpackage

// File: rtl/can_tec_counter.sv
// Purpose: saturating 9-bit transmit error counter, +8 on inc, -1 on dec (floor 0), clear wins.
// Latency: tec updates on the clock edge; err_passive is combinational from tec, busoff_req from next value.
// Backpressure: none; inc/dec/clr are single-cycle strobes.
// Ports: clk, reset (async, active-high), inc, dec, clr -> tec, err_passive, busoff_req.
module can_tec_counter
    import can_err_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [TEC_W-1:0] tec,
    output logic             err_passive,
    output logic             busoff_req
);

    logic [TEC_W:0]   inc_sum;
    logic [TEC_W-1:0] tec_nxt;

    always_comb begin
        inc_sum = {1'b0, tec} + {1'b0, TEC_ERR_INC};
        tec_nxt = tec;
        if (clr) begin
            tec_nxt = '0;
        end else if (inc) begin
            // carry out of the 9-bit sum means saturate at all-ones
            tec_nxt = inc_sum[TEC_W] ? '1 : inc_sum[TEC_W-1:0];
        end else if (dec && (tec != '0)) begin
            tec_nxt = tec - TEC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tec <= '0;
        else       tec <= tec_nxt;
    end

    assign err_passive = (tec >= TEC_PASSIVE);
    // Only an increment can cross into bus-off; flag it on the same edge.
    assign busoff_req  = inc && (tec_nxt >= TEC_BUSOFF);

endmodule

// File: rtl/can_error_frame_tx.sv
// Purpose: drives a CAN error frame (6-bit flag + 8-bit recessive delimiter) on tx_bit and tracks TEC/bus-off.
// Latency: request latched on any clk, frame starts on the next bit_tick; all bit-level moves on bit_tick only.
// Backpressure: none; requests arriving while not idle are dropped, busy shows a frame in progress.
// Ports: clk, reset (async, active-high), bit_tick, rx_bit, err_n, tx_ok -> tx_bit, busy, err_passive, bus_off, tec.
// Build option: define ERR_FRAME_STATS_EN to add err_frames[15:0], a saturating count of flag starts.
module can_error_frame_tx
    import can_err_pkg::*;
#(
    parameter int FLAG_LEN       = FLAG_LEN_DEF,
    parameter int DELIM_LEN      = DELIM_LEN_DEF,
    parameter int MAX_DOM_WAIT   = 14,
    parameter int BUSOFF_RECOVER = 1408
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_tick,
    input  logic             rx_bit,
    input  logic             err_n,
    input  logic             tx_ok,
    output logic             tx_bit,
    output logic             busy,
    output logic             err_passive,
    output logic             bus_off,
    output logic [TEC_W-1:0] tec
`ifdef ERR_FRAME_STATS_EN
    ,
    output logic [15:0]      err_frames
`endif
);

    localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int DCNT_W  = $clog2(MAX_DOM_WAIT);
    localparam int RCNT_W  = $clog2(BUSOFF_RECOVER);

    logic [2:0]        state, state_pre, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt;
    logic [RCNT_W-1:0] rcnt, rcnt_pre, rcnt_nxt;
    logic              pending, pend_nxt;
    logic              tec_inc, tec_dec, tec_clr, busoff_req;

    can_tec_counter u_tec (
        .clk         (clk),
        .reset       (reset),
        .inc         (tec_inc),
        .dec         (tec_dec),
        .clr         (tec_clr),
        .tec         (tec),
        .err_passive (err_passive),
        .busoff_req  (busoff_req)
    );

    always_comb begin
        state_pre = state;
        cnt_nxt   = cnt;
        dcnt_nxt  = dcnt;
        rcnt_pre  = rcnt;
        pend_nxt  = pending;
        tec_inc   = 1'b0;
        tec_dec   = 1'b0;
        tec_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!err_n) pend_nxt = 1'b1;
                if (bit_tick && pending) begin
                    state_pre = ST_FLAG;
                    cnt_nxt   = '0;
                    tec_inc   = 1'b1;
                    pend_nxt  = 1'b0;
                end else if (tx_ok && err_n && !pending) begin
                    // a live or latched request suppresses the success decrement
                    tec_dec = 1'b1;
                end
            end
            ST_FLAG: begin
                if (bit_tick) begin
                    if (cnt == CNT_W'(FLAG_LEN - 1)) begin
                        state_pre = ST_DELIM_WAIT;
                        dcnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DELIM_WAIT: begin
                if (bit_tick) begin
                    if (rx_bit) begin
                        // this recessive sample is already delimiter bit 1
                        state_pre = ST_DELIM;
                        cnt_nxt   = CNT_W'(1);
                    end else if (dcnt == DCNT_W'(MAX_DOM_WAIT - 1)) begin
                        tec_inc  = 1'b1;
                        dcnt_nxt = '0;
                    end else begin
                        dcnt_nxt = dcnt + DCNT_W'(1);
                    end
                end
            end
            ST_DELIM: begin
                if (bit_tick) begin
                    if (!rx_bit) begin
                        // form error: restart the flag
                        state_pre = ST_FLAG;
                        cnt_nxt   = '0;
                        tec_inc   = 1'b1;
                    end else if (cnt == CNT_W'(DELIM_LEN - 1)) begin
                        state_pre = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_BUS_OFF: begin
                if (bit_tick) begin
                    if (!rx_bit) begin
                        rcnt_pre = '0;
                    end else if (rcnt == RCNT_W'(BUSOFF_RECOVER - 1)) begin
                        rcnt_pre  = '0;
                        tec_clr   = 1'b1;
                        state_pre = ST_IDLE;
                    end else begin
                        rcnt_pre = rcnt + RCNT_W'(1);
                    end
                end
            end
            default: state_pre = ST_IDLE;
        endcase
    end

    // Crossing into bus-off overrides whatever the frame logic wanted.
    assign state_nxt = busoff_req ? ST_BUS_OFF : state_pre;
    assign rcnt_nxt  = busoff_req ? '0 : rcnt_pre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dcnt    <= '0;
            rcnt    <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dcnt    <= dcnt_nxt;
            rcnt    <= rcnt_nxt;
            pending <= pend_nxt;
        end
    end

    // Decoded from state so reset forces recessive without waiting for a clock.
    assign tx_bit  = (state == ST_FLAG) ? err_passive : 1'b1;
    assign busy    = (state == ST_FLAG) || (state == ST_DELIM_WAIT) || (state == ST_DELIM);
    assign bus_off = (state == ST_BUS_OFF);

`ifdef ERR_FRAME_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_frames <= '0;
        end else if ((state_nxt == ST_FLAG) && (state != ST_FLAG) && (err_frames != 16'hFFFF)) begin
            err_frames <= err_frames + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_can_error_frame_tx.sv
module tb_can_error_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_tick = 1'b0;
    logic       rx_bit = 1'b1;
    logic       err_n = 1'b1;
    logic       tx_ok = 1'b0;
    logic       tx_bit, busy, err_passive, bus_off;
    logic [8:0] tec;
`ifdef ERR_FRAME_STATS_EN
    logic [15:0] err_frames;
`endif

    int tests_run = 0;
    int failed    = 0;
    int bper      = 3;   // clocks per bit time

    can_error_frame_tx dut (
        .clk         (clk),
        .reset       (reset),
        .bit_tick    (bit_tick),
        .rx_bit      (rx_bit),
        .err_n       (err_n),
        .tx_ok       (tx_ok),
        .tx_bit      (tx_bit),
        .busy        (busy),
        .err_passive (err_passive),
        .bus_off     (bus_off),
        .tec         (tec)
`ifdef ERR_FRAME_STATS_EN
        ,
        .err_frames  (err_frames)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame-level view) ----------------
    int m_tec;        // transmit error counter
    bit m_boff;       // in bus-off
    int flag_left;    // flag bit times still to send (>0 means sending flag)
    bit m_wait;       // flag done, waiting for recessive bus
    int m_dom;        // dominant bits seen while waiting
    int m_delim;      // recessive delimiter bits seen (>0 means in delimiter)
    bit m_pend;       // latched request
    int m_rec;        // consecutive recessive bits in bus-off
    int m_frames;     // flag starts

    function automatic void model_reset();
        m_tec = 0; m_boff = 0; flag_left = 0; m_wait = 0; m_dom = 0;
        m_delim = 0; m_pend = 0; m_rec = 0; m_frames = 0;
    endfunction

    function automatic void penalty();
        m_tec = (m_tec + 8 > 511) ? 511 : m_tec + 8;
        if (m_tec >= 256) begin
            m_boff = 1; m_rec = 0; flag_left = 0; m_wait = 0; m_delim = 0;
        end
    endfunction

    function automatic void start_flag();
        m_wait = 0; m_delim = 0;
        penalty();
        if (!m_boff) begin
            flag_left = 6;
            if (m_frames < 65535) m_frames++;
        end
    endfunction

    function automatic void model_edge(bit tick, bit rx, bit en, bit ok);
        bit idle;
        idle = !m_boff && flag_left == 0 && !m_wait && m_delim == 0;
        if (idle) begin
            if (tick && m_pend) begin
                m_pend = 0;
                start_flag();
            end else begin
                if (ok && en && !m_pend && m_tec > 0) m_tec--;
                if (!en) m_pend = 1;
            end
        end else if (tick) begin
            if (m_boff) begin
                if (rx) begin
                    m_rec++;
                    if (m_rec == 1408) begin m_boff = 0; m_tec = 0; m_rec = 0; end
                end else m_rec = 0;
            end else if (flag_left > 0) begin
                flag_left--;
                if (flag_left == 0) begin m_wait = 1; m_dom = 0; end
            end else if (m_wait) begin
                if (rx) begin m_wait = 0; m_delim = 1; end
                else begin
                    m_dom++;
                    if (m_dom == 14) begin m_dom = 0; penalty(); end
                end
            end else begin
                if (!rx) start_flag();
                else begin
                    m_delim++;
                    if (m_delim == 8) m_delim = 0;
                end
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        tests_run++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("tx_bit", {15'd0, tx_bit}, (flag_left > 0) ? 16'(m_tec >= 128) : 16'd1);
        chk("busy", {15'd0, busy}, 16'(flag_left > 0 || m_wait || m_delim > 0));
        chk("err_passive", {15'd0, err_passive}, 16'(m_tec >= 128));
        chk("bus_off", {15'd0, bus_off}, 16'(m_boff));
        chk("tec", {7'd0, tec}, 16'(m_tec));
`ifdef ERR_FRAME_STATS_EN
        chk("err_frames", err_frames, 16'(m_frames));
`endif
    endtask

    // one clock: drive, edge, update model, check 1 time unit later
    task automatic cyc(bit tick, bit rx, bit en, bit ok);
        bit_tick = tick; rx_bit = rx; err_n = en; tx_ok = ok;
        @(posedge clk);
        model_edge(tick, rx, en, ok);
        #1;
        chk_model();
    endtask

    task automatic bits(int n, bit rx);
        for (int i = 0; i < n; i++) begin
            for (int j = 1; j < bper; j++) cyc(0, rx, 1, 0);
            cyc(1, rx, 1, 0);
        end
    endtask

    task automatic req();
        cyc(0, 1, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, 1, 0);
    endtask

    int zeros, fall_at;

    initial begin
        model_reset();
        #1;
        // reset state
        chk("rst_tx_bit", {15'd0, tx_bit}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_tec", {7'd0, tec}, 16'd0);
        chk("rst_passive", {15'd0, err_passive}, 16'd0);
        chk("rst_bus_off", {15'd0, bus_off}, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, 1, 0);

        // active error frame: 6 dominant, busy drops at tick 14 after start
        req();
        zeros = 0; fall_at = -1;
        for (int k = 0; k < 16; k++) begin
            bits(1, 1);
            if (tx_bit == 1'b0) zeros++;
            if (!busy && fall_at < 0) fall_at = k;
        end
        chk("active_dom_bits", 16'(zeros), 16'd6);
        chk("active_busy_fall", 16'(fall_at), 16'd14);
        chk("active_tec", {7'd0, tec}, 16'd8);

        // decrement, then request coinciding with tx_ok
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1);
        chk("dec_tec", {7'd0, tec}, 16'd5);
        cyc(0, 1, 0, 1);
        bits(15, 1);
        chk("req_wins_tec", {7'd0, tec}, 16'd13);

        // error-passive: 16 frames from zero, then a recessive flag
        do_reset();
        bper = 2;
        for (int f = 0; f < 16; f++) begin req(); bits(15, 1); end
        chk("passive_tec", {7'd0, tec}, 16'd128);
        chk("passive_flag", {15'd0, err_passive}, 16'd1);
        req();
        zeros = 0;
        for (int k = 0; k < 15; k++) begin
            bits(1, 1);
            if (tx_bit == 1'b0) zeros++;
        end
        chk("passive_dom_bits", 16'(zeros), 16'd0);
        chk("passive_tec2", {7'd0, tec}, 16'd136);

        // delimiter wait: 20 dominant bits, one extra penalty at the 14th
        req();
        bits(7, 1);
        chk("dw_tec_entry", {7'd0, tec}, 16'd144);
        bits(13, 0);
        chk("dw_tec_13", {7'd0, tec}, 16'd144);
        bits(1, 0);
        chk("dw_tec_14", {7'd0, tec}, 16'd152);
        bits(6, 0);
        chk("dw_tec_20", {7'd0, tec}, 16'd152);
        bits(7, 1);
        chk("dw_busy_7rec", {15'd0, busy}, 16'd1);
        bits(1, 1);
        chk("dw_busy_8rec", {15'd0, busy}, 16'd0);

        // form error at delimiter bit 4
        do_reset();
        bper = 3;
        req();
        bits(7, 1);
        bits(3, 1);
        bits(1, 0);
        chk("form_tec", {7'd0, tec}, 16'd16);
        chk("form_tx_bit", {15'd0, tx_bit}, 16'd0);
        chk("form_busy", {15'd0, busy}, 16'd1);
`ifdef ERR_FRAME_STATS_EN
        chk("form_frames", err_frames, 16'd2);
`endif
        bits(15, 1);
        chk("form_done", {15'd0, busy}, 16'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0);
        end

        // bus-off entry through delimiter-wait penalties, then recovery
        do_reset();
        bper = 1;
        req();
        bits(7, 1);
        bits(14 * 31, 0);
        chk("boff_flag", {15'd0, bus_off}, 16'd1);
        chk("boff_tec", {7'd0, tec}, 16'd256);
        chk("boff_tx_bit", {15'd0, tx_bit}, 16'd1);
        chk("boff_busy", {15'd0, busy}, 16'd0);
        bits(700, 1);
        bits(1, 0);
        cyc(0, 1, 0, 1);
        bits(1407, 1);
        chk("boff_1407", {15'd0, bus_off}, 16'd1);
        bits(1, 1);
        chk("boff_recover", {15'd0, bus_off}, 16'd0);
        chk("boff_tec_clr", {7'd0, tec}, 16'd0);
        bits(2, 1);
        chk("boff_req_ignored", {15'd0, busy}, 16'd0);

        // async reset in the middle of a flag
        bper = 3;
        req();
        bits(3, 1);
        chk("mid_flag_dom", {15'd0, tx_bit}, 16'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tx_bit", {15'd0, tx_bit}, 16'd1);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        chk("arst_tec", {7'd0, tec}, 16'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, 1, 0);
        bits(2, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
